instr_fetch_unit: RTL and testbench

//  Producer side of the instruction-decode interface. Holds the fetch PC,

---
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, 1-cycle synchronous imem reads and a valid/ready instruction FIFO toward decode
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [6:0]            opcode_o,
  output logic                  illegal_o
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [ADDR_WIDTH-1:0] pc, inflight_pc;
  logic                  inflight;
  logic [31:0]           instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid_o     = !rst && count != '0;
  assign pop         = valid_o && ready_i;
  assign push        = inflight && !redirect_i;
  assign occ         = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_req_o  = !rst && !redirect_i && occ < (CW+1)'(FIFO_DEPTH);
  assign imem_addr_o = pc;
  assign instr_o     = instr_q[rd_ptr];
  assign pc_o        = pc_q[rd_ptr];
  assign opcode_o    = instr_o[6:0];
  assign illegal_o   = valid_o && !(opcode_o inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011,
                        7'b1100011, 7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111});
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      pc       <= redirect_pc_i & ~ADDR_WIDTH'(3);
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) pc <= pc + ADDR_WIDTH'(4);
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (imem_req_o) inflight_pc <= pc;
    if (push && !rst) begin
      instr_q[wr_ptr] <= imem_rdata_i;
      pc_q[wr_ptr]    <= inflight_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) assert (count != CW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit streaming, backpressure, redirect, decode and wrap
module tb_instr_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, imem_req_o, redirect_i, valid_o, ready_i, illegal_o;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, pc_o;
  logic [6:0]  opcode_o;
  logic        req2, valid2, illegal2;
  logic        redirect2 = 1'b0;
  logic        ready2 = 1'b1;
  logic [31:0] addr2, rdata2, instr2, pc2;
  logic [31:0] redirect_pc2 = '0;
  logic [6:0]  opcode2;
  exp_t        sb[$];
  exp_t        e;
  int          compared = 0;
  int          mismatched = 0;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .illegal_o(illegal_o)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rdata_i(rdata2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .valid_o(valid2), .ready_i(ready2), .instr_o(instr2), .pc_o(pc2),
    .opcode_o(opcode2), .illegal_o(illegal2)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h200 ? 32'h0000_0013 : a == 32'h204 ? 32'h0000_007F : a == 32'h208 ? 32'h0000_006F : a;
  endfunction
  always @(posedge clk) begin
    imem_rdata_i <= mem_word(imem_addr_o);
    rdata2       <= mem_word(addr2);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic ill);
    exp_t x;
    x.pc = pc;
    x.instr = instr;
    x.ill = ill;
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_delivery: got pc %h expected no delivery", pc_o);
      end else begin
        e = sb.pop_front();
        if ({pc_o, instr_o, opcode_o, illegal_o} !== {e.pc, e.instr, e.instr[6:0], e.ill}) begin
          mismatched++;
          $display("FAIL delivery: got pc %h instr %h op %h ill %b expected pc %h instr %h op %h ill %b",
                   pc_o, instr_o, opcode_o, illegal_o, e.pc, e.instr, e.instr[6:0], e.ill);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    for (int i = 0; i < 12; i++) push_exp(32'(4 * i), 32'(4 * i), 1'b1);
    for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), 1'b1);
    push_exp(32'h200, 32'h0000_0013, 1'b0);
    push_exp(32'h204, 32'h0000_007F, 1'b1);
    push_exp(32'h208, 32'h0000_006F, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), 1'b1);
    for (int i = 0; i < 3; i++) push_exp(32'h400 + 32'(4 * i), 32'h400 + 32'(4 * i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      redirect_i = i == 1;
      redirect_pc_i = 32'h500;
      @(negedge clk);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_req", 32'(imem_req_o), 0);
      chk("rst_illegal", 32'(illegal_o), 0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 47; c++) begin
      rst = c >= 44;
      ready_i = !((c >= 10 && c <= 15) || (c >= 20 && c <= 21));
      redirect_i = c == 21 || c == 27 || c == 32 || c == 37 || c == 38;
      redirect_pc_i = c == 21 ? 32'h100 : c == 27 ? 32'h200 : c == 32 ? 32'h103 : c == 37 ? 32'h300 : 32'h400;
      @(negedge clk);
      if (c == 0) begin
        chk("rel_req", 32'(imem_req_o), 1);
        chk("rel_addr", imem_addr_o, 0);
        chk("rel_valid", 32'(valid_o), 0);
        chk("wrap_req", 32'(req2), 1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      end
      if (c == 1) begin
        chk("lat_valid", 32'(valid_o), 0);
        chk("lat_addr", imem_addr_o, 4);
        chk("wrap_addr1", addr2, 0);
      end
      if (c == 2) chk("first_valid", 32'(valid_o), 1);
      if (c >= 10 && c <= 15) begin
        chk("bp_valid", 32'(valid_o), 1);
        chk("bp_pc", pc_o, 32);
        chk("bp_instr", instr_o, 32);
        chk("bp_req", 32'(imem_req_o), 0);
      end
      if (c == 16) begin
        chk("resume_req", 32'(imem_req_o), 1);
        chk("resume_addr", imem_addr_o, 40);
      end
      if (c == 21) begin
        chk("redir_full_pc", pc_o, 48);
        chk("redir_noreq", 32'(imem_req_o), 0);
      end
      if (c == 22 || c == 28 || c == 33) begin
        chk("redir_valid", 32'(valid_o), 0);
        chk("redir_req", 32'(imem_req_o), 1);
        chk("redir_addr", imem_addr_o, c == 22 ? 32'h100 : c == 28 ? 32'h200 : 32'h100);
      end
      if (c == 30) begin
        chk("op_addi", 32'(opcode_o), 32'h13);
        chk("ill_addi", 32'(illegal_o), 0);
      end
      if (c == 31) begin
        chk("op_7f", 32'(opcode_o), 32'h7F);
        chk("ill_7f", 32'(illegal_o), 1);
      end
      if (c == 38) begin
        chk("b2b_valid", 32'(valid_o), 0);
        chk("b2b_noreq", 32'(imem_req_o), 0);
      end
      if (c == 39) begin
        chk("b2b_valid2", 32'(valid_o), 0);
        chk("b2b_addr", imem_addr_o, 32'h400);
      end
      if (c == 44) begin
        chk("final_rst_valid", 32'(valid_o), 0);
        chk("final_rst_req", 32'(imem_req_o), 0);
        chk("final_rst_ill", 32'(illegal_o), 0);
      end
      @(posedge clk);
      #1;
    end
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
